id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the 10-bit decode control word, the load result-source
// encoding and the register index width.
package cpu_pkg;
  localparam int         REG_IDX_W   = 5;
  localparam int         CTRL_W      = 10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Bit order matches the pipeline bus: {ALUControl, ALUSrc, RegWrite,
  // MemWrite, ResultSrc, Branch, Jump}. All-zero decodes to a no-op.
  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
  } ctrl_t;

  function automatic logic is_load(ctrl_t c);
    return c.result_src == RESULT_LOAD;
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector.
// Ports:
//   i_e_valid, i_e_ctrl, i_e_rd : instruction currently in execute
//   i_d_valid, i_d_rs1, i_d_rs2 : instruction currently in decode
//   o_hazard                    : decode reads the register a load in execute writes
module hazard_detect
  import cpu_pkg::*;
(
  input  logic                 i_e_valid,
  input  ctrl_t                i_e_ctrl,
  input  logic [REG_IDX_W-1:0] i_e_rd,
  input  logic                 i_d_valid,
  input  logic [REG_IDX_W-1:0] i_d_rs1,
  input  logic [REG_IDX_W-1:0] i_d_rs2,
  output logic                 o_hazard
);
  logic w_src_match;

  assign w_src_match = (i_e_rd == i_d_rs1) || (i_e_rd == i_d_rs2);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign o_hazard = i_e_valid && is_load(i_e_ctrl) && (i_e_rd != '0) &&
                    i_d_valid && w_src_match;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush handling.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   d_valid, d_ctrl, d_rd1..d_pc,
//   d_rs1, d_rs2, d_rd               : decode-stage instruction
//   flush_i                          : kill the decode instruction (taken branch/jump)
//   e_valid, e_ctrl, e_rd1..e_pc,
//   e_rs1, e_rs2, e_rd               : registered execute-stage instruction
//   stall_o                          : combinational, hold PC and IF/ID this cycle
//   bubble_cnt                       : saturating count of bubbles replacing real instructions
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d_valid,
  input  logic [CTRL_W-1:0]    d_ctrl,
  input  logic [DATA_W-1:0]    d_rd1,
  input  logic [DATA_W-1:0]    d_rd2,
  input  logic [DATA_W-1:0]    d_imm,
  input  logic [DATA_W-1:0]    d_pc,
  input  logic [REG_IDX_W-1:0] d_rs1,
  input  logic [REG_IDX_W-1:0] d_rs2,
  input  logic [REG_IDX_W-1:0] d_rd,
  input  logic                 flush_i,
  output logic                 e_valid,
  output logic [CTRL_W-1:0]    e_ctrl,
  output logic [DATA_W-1:0]    e_rd1,
  output logic [DATA_W-1:0]    e_rd2,
  output logic [DATA_W-1:0]    e_imm,
  output logic [DATA_W-1:0]    e_pc,
  output logic [REG_IDX_W-1:0] e_rs1,
  output logic [REG_IDX_W-1:0] e_rs2,
  output logic [REG_IDX_W-1:0] e_rd,
  output logic                 stall_o,
  output logic [CNT_W-1:0]     bubble_cnt
);
  logic                 r_valid;
  ctrl_t                r_ctrl;
  logic [DATA_W-1:0]    r_rd1, r_rd2, r_imm, r_pc;
  logic [REG_IDX_W-1:0] r_rs1, r_rs2, r_rd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_hazard;
  logic                 w_bubble;

  hazard_detect u_hazard (
    .i_e_valid (r_valid),
    .i_e_ctrl  (r_ctrl),
    .i_e_rd    (r_rd),
    .i_d_valid (d_valid),
    .i_d_rs1   (d_rs1),
    .i_d_rs2   (d_rs2),
    .o_hazard  (w_hazard)
  );

  // A flush already discards the decode instruction, so stalling would only
  // hold a dead instruction; flush wins and the stall is suppressed.
  assign stall_o  = w_hazard && !flush_i && rst_n;
  assign w_bubble = flush_i || w_hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else if (w_bubble) begin
      // Zero control is a no-op; data/index fields are left as-is.
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (d_valid && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_valid <= d_valid;
      r_ctrl  <= d_valid ? ctrl_t'(d_ctrl) : '0;
      r_rd1   <= d_rd1;
      r_rd2   <= d_rd2;
      r_imm   <= d_imm;
      r_pc    <= d_pc;
      r_rs1   <= d_rs1;
      r_rs2   <= d_rs2;
      r_rd    <= d_rd;
    end
  end

  assign e_valid    = r_valid;
  assign e_ctrl     = r_ctrl;
  assign e_rd1      = r_rd1;
  assign e_rd2      = r_rd2;
  assign e_imm      = r_imm;
  assign e_pc       = r_pc;
  assign e_rs1      = r_rs1;
  assign e_rs2      = r_rs2;
  assign e_rd       = r_rd;
  assign bubble_cnt = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_valid = 1'b0;
  logic [9:0]  d_ctrl = '0;
  logic [31:0] d_rd1 = '0, d_rd2 = '0, d_imm = '0, d_pc = '0;
  logic [4:0]  d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic        flush_i = 1'b0;
  logic        e_valid;
  logic [9:0]  e_ctrl;
  logic [31:0] e_rd1, e_rd2, e_imm, e_pc;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic        stall_o;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int fails  = 0;

  // Behavioural model of what execute should hold.
  logic        m_v = 1'b0;
  logic [9:0]  m_ctrl = '0;
  logic [31:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0, m_pc = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  int unsigned m_cnt = 0;

  localparam logic [9:0] LBU = 10'h064; // ALUSrc, RegWrite, ResultSrc=01
  localparam logic [9:0] ADD = 10'h020; // RegWrite only

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_ctrl(d_ctrl),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_pc(d_pc),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .flush_i(flush_i),
    .e_valid(e_valid), .e_ctrl(e_ctrl), .e_rd1(e_rd1), .e_rd2(e_rd2),
    .e_imm(e_imm), .e_pc(e_pc), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [169:0] dut_vec();
    return {e_valid, e_ctrl, e_rd1, e_rd2, e_imm, e_pc, e_rs1, e_rs2, e_rd, bubble_cnt};
  endfunction

  function automatic logic [169:0] model_vec();
    logic [15:0] c;
    c = (m_cnt > 32'd65535) ? 16'hFFFF : m_cnt[15:0];
    return {m_v, m_ctrl, m_rd1, m_rd2, m_imm, m_pc, m_rs1, m_rs2, m_rd, c};
  endfunction

  // A load (ResultSrc=01) in execute writing a nonzero register read by decode.
  function automatic logic model_hazard();
    return m_v && (m_ctrl[3:2] == 2'b01) && (m_rd != 5'd0) && d_valid &&
           (m_rd == d_rs1 || m_rd == d_rs2);
  endfunction

  task automatic step();
    logic hz;
    hz = model_hazard();
    @(posedge clk);
    if (!rst_n) begin
      m_v = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0;
    end else if (flush_i || hz) begin
      m_v = 0; m_ctrl = 0;
      if (d_valid) m_cnt++;
    end else begin
      m_v = d_valid; m_ctrl = d_valid ? d_ctrl : 10'd0;
      m_rd1 = d_rd1; m_rd2 = d_rd2; m_imm = d_imm; m_pc = d_pc;
      m_rs1 = d_rs1; m_rs2 = d_rs2; m_rd = d_rd;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    d_valid = v; d_ctrl = c; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
    d_rd1 = $urandom; d_rd2 = $urandom; d_imm = $urandom; d_pc = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 0; flush_i = 0;
    drive(1'b1, 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    step();
    drive(1'b1, 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    step();
    checks++;
    if (dut_vec() !== 170'd0) begin
      fails++; $display("FAIL reset_outputs got=%h want=0", dut_vec());
    end
    checks++;
    if (stall_o !== 1'b0) begin
      fails++; $display("FAIL reset_stall got=%b want=0", stall_o);
    end
    rst_n = 1;
  endtask

  task automatic test_passthrough();
    drive(1'b1, 10'h2A4, 5'd9, 5'd10, 5'd11);
    d_rd1 = 32'h1234_5678;
    step();
    checks++;
    if (e_ctrl !== 10'h2A4 || e_rd1 !== 32'h1234_5678 || e_valid !== 1'b1) begin
      fails++;
      $display("FAIL passthrough got ctrl=%h rd1=%h v=%b want 2a4 12345678 1", e_ctrl, e_rd1, e_valid);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL passthrough_all got=%h want=%h", dut_vec(), model_vec());
    end
    // Invalid decode must not leak its control word.
    drive(1'b0, 10'h3FF, 5'd11, 5'd11, 5'd3);
    step();
    checks++;
    if (e_valid !== 1'b0 || e_ctrl !== 10'd0 || e_rd !== 5'd3) begin
      fails++; $display("FAIL invalid_capture got v=%b ctrl=%h rd=%0d want 0 0 3", e_valid, e_ctrl, e_rd);
    end
  endtask

  task automatic test_load_use();
    int unsigned base;
    drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0); step();
    base = m_cnt;
    drive(1'b1, LBU, 5'd2, 5'd3, 5'd5); step();
    drive(1'b1, ADD, 5'd1, 5'd5, 5'd7); #1;
    checks++;
    if (stall_o !== 1'b1) begin
      fails++; $display("FAIL loaduse_stall got=%b want=1", stall_o);
    end
    step();
    checks++;
    if (e_valid !== 1'b0 || e_ctrl !== 10'd0 || bubble_cnt !== 16'(base + 1) || stall_o !== 1'b0) begin
      fails++;
      $display("FAIL loaduse_bubble got v=%b ctrl=%h cnt=%0d stall=%b want 0 0 %0d 0",
               e_valid, e_ctrl, bubble_cnt, stall_o, base + 1);
    end
    step();
    checks++;
    if (e_valid !== 1'b1 || e_ctrl !== ADD || e_rd !== 5'd7 || e_rs2 !== 5'd5) begin
      fails++;
      $display("FAIL loaduse_enter got v=%b ctrl=%h rd=%0d rs2=%0d want 1 020 7 5", e_valid, e_ctrl, e_rd, e_rs2);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL loaduse_all got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    logic [3:0] st;
    drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0); step();
    base = m_cnt;
    drive(1'b1, LBU, 5'd1, 5'd1, 5'd5); step();        // load x5
    drive(1'b1, LBU, 5'd5, 5'd0, 5'd6); #1; st[0] = stall_o; step(); // load x6 <- x5
    #1; st[1] = stall_o; step();                        // load x6 enters
    drive(1'b1, ADD, 5'd6, 5'd2, 5'd8); #1; st[2] = stall_o; step(); // add <- x6
    #1; st[3] = stall_o; step();
    checks++;
    if (st !== 4'b0101 || bubble_cnt !== 16'(base + 2) || e_ctrl !== ADD || e_rd !== 5'd8) begin
      fails++;
      $display("FAIL back_to_back got stalls=%b cnt=%0d ctrl=%h rd=%0d want 0101 %0d 020 8",
               st, bubble_cnt, e_ctrl, e_rd, base + 2);
    end
  endtask

  task automatic test_x0_load();
    int unsigned base;
    drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0); step();
    base = m_cnt;
    drive(1'b1, LBU, 5'd3, 5'd4, 5'd0); step();
    drive(1'b1, ADD, 5'd0, 5'd0, 5'd9); #1;
    checks++;
    if (stall_o !== 1'b0) begin
      fails++; $display("FAIL x0_stall got=%b want=0", stall_o);
    end
    step();
    checks++;
    if (bubble_cnt !== 16'(base) || e_valid !== 1'b1 || e_rd !== 5'd9) begin
      fails++; $display("FAIL x0_nobubble got cnt=%0d v=%b rd=%0d want %0d 1 9", bubble_cnt, e_valid, e_rd, base);
    end
  endtask

  task automatic test_flush_hazard();
    int unsigned base;
    drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0); step();
    base = m_cnt;
    drive(1'b1, LBU, 5'd1, 5'd1, 5'd5); step();
    drive(1'b1, ADD, 5'd2, 5'd5, 5'd7); flush_i = 1; #1;
    checks++;
    if (stall_o !== 1'b0) begin
      fails++; $display("FAIL flush_stall got=%b want=0", stall_o);
    end
    step();
    flush_i = 0;
    checks++;
    if (e_valid !== 1'b0 || e_ctrl !== 10'd0 || bubble_cnt !== 16'(base + 1)) begin
      fails++; $display("FAIL flush_bubble got v=%b ctrl=%h cnt=%0d want 0 0 %0d", e_valid, e_ctrl, bubble_cnt, base + 1);
    end
  endtask

  task automatic test_reset_during_stall();
    drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0); step();
    drive(1'b1, LBU, 5'd1, 5'd1, 5'd5); step();
    drive(1'b1, ADD, 5'd5, 5'd5, 5'd7); rst_n = 0; #1;
    checks++;
    if (stall_o !== 1'b0) begin
      fails++; $display("FAIL rststall_stall got=%b want=0", stall_o);
    end
    step();
    rst_n = 1;
    checks++;
    if (dut_vec() !== 170'd0) begin
      fails++; $display("FAIL rststall_outputs got=%h want=0", dut_vec());
    end
  endtask

  task automatic test_random();
    logic exp_stall;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 10'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush_i = ($urandom_range(0, 7) == 0);
      rst_n   = ($urandom_range(0, 49) != 0);
      #1;
      exp_stall = model_hazard() && !flush_i && rst_n;
      checks++;
      if (stall_o !== exp_stall) begin
        fails++; $display("FAIL rand_stall[%0d] got=%b want=%b", i, stall_o, exp_stall);
      end
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL rand_state[%0d] got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    rst_n = 1; flush_i = 0;
  endtask

  task automatic test_saturation();
    drive(1'b1, ADD, 5'd1, 5'd2, 5'd3);
    flush_i = 1;
    for (int i = 0; i < 65536 + 3; i++) step();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL saturation got=%h want=ffff", bubble_cnt);
    end
    flush_i = 0;
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL saturation_all got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_back_to_back();
    test_x0_load();
    test_flush_hazard();
    test_reset_during_stall();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
